// File: rtl/vga_plot_sink.sv
// vga_plot_sink
//   Receiving end of the processor's VGA plot interface. Plot requests are
//   range-checked, converted to a linear framebuffer address (y*WIDTH + x)
//   and buffered in a small FIFO that drains through a valid/ready write
//   port. A falling edge on vga_resetn flushes the FIFO and sweeps every
//   pixel to CLEAR_COLOR.
//
// Ports
//   clock, resetn         : rising-edge clock, asynchronous active-low reset
//   vga_color/x/y/plot    : plot request, sampled every cycle
//   vga_resetn            : active-low clear request (falling edge triggers)
//   fb_addr/fb_data/fb_we : framebuffer write request (held until fb_ready)
//   fb_ready              : framebuffer accepts the write this cycle
//   busy                  : clearing, or FIFO non-empty
//   overflow, range_error : sticky drop flags, cleared only by resetn
module vga_plot_sink #(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned WIDTH       = 160,
  parameter int unsigned HEIGHT      = 120,
  parameter logic [14:0] CLEAR_COLOR = 15'h0000
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [14:0] vga_color,
  input  logic [7:0]  vga_x,
  input  logic [6:0]  vga_y,
  input  logic        vga_plot,
  input  logic        vga_resetn,
  output logic [14:0] fb_addr,
  output logic [14:0] fb_data,
  output logic        fb_we,
  input  logic        fb_ready,
  output logic        busy,
  output logic        overflow,
  output logic        range_error
);

  localparam int unsigned AW        = $clog2(DEPTH);
  localparam logic [14:0] LAST_ADDR = 15'(WIDTH * HEIGHT - 1);
  localparam logic [8:0]  WIDTH_L   = 9'(WIDTH);
  localparam logic [7:0]  HEIGHT_L  = 8'(HEIGHT);
  localparam logic [14:0] WIDTH_A   = 15'(WIDTH);

  typedef enum logic {ST_RUN, ST_CLEAR} state_e;

  state_e      state_q, state_d;
  logic        vga_resetn_q;
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [14:0] clr_addr_q, clr_addr_d;
  logic        overflow_q, overflow_d;
  logic        range_q, range_d;
  logic [29:0] mem_q [DEPTH];

  logic        clear_req;
  logic        empty;
  logic        full;
  logic        in_range;
  logic        push;
  logic        pop;
  logic [14:0] plot_addr;
  logic [29:0] head;

  assign clear_req = vga_resetn_q & ~vga_resetn;
  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign in_range  = ({1'b0, vga_x} < WIDTH_L) && ({1'b0, vga_y} < HEIGHT_L);
  assign plot_addr = 15'(vga_y) * WIDTH_A + 15'(vga_x);
  assign head      = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    clr_addr_d = clr_addr_q;
    overflow_d = overflow_q;
    range_d    = range_q;
    push       = 1'b0;
    pop        = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (clear_req) begin
          // Flush abandons any pending head write; same-cycle plot is lost.
          wr_ptr_d   = '0;
          rd_ptr_d   = '0;
          clr_addr_d = '0;
          state_d    = ST_CLEAR;
        end else begin
          if (vga_plot) begin
            if (!in_range)  range_d    = 1'b1;
            else if (full)  overflow_d = 1'b1;
            else            push       = 1'b1;
          end
          pop = !empty && fb_ready;
          if (push) wr_ptr_d = wr_ptr_q + 1'b1;
          if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        end
      end
      ST_CLEAR: begin
        if (fb_ready) begin
          if (clr_addr_q == LAST_ADDR) begin
            clr_addr_d = '0;
            state_d    = ST_RUN;
          end else begin
            clr_addr_d = clr_addr_q + 15'd1;
          end
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_comb begin
    fb_we   = 1'b0;
    fb_addr = '0;
    fb_data = '0;
    if (state_q == ST_CLEAR) begin
      fb_we   = 1'b1;
      fb_addr = clr_addr_q;
      fb_data = CLEAR_COLOR;
    end else if (!empty) begin
      fb_we   = 1'b1;
      fb_addr = head[29:15];
      fb_data = head[14:0];
    end
  end

  assign busy        = (state_q == ST_CLEAR) || !empty;
  assign overflow    = overflow_q;
  assign range_error = range_q;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_RUN;
      vga_resetn_q <= 1'b1;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      clr_addr_q   <= '0;
      overflow_q   <= 1'b0;
      range_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      vga_resetn_q <= vga_resetn;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      clr_addr_q   <= clr_addr_d;
      overflow_q   <= overflow_d;
      range_q      <= range_d;
    end
  end

  // Storage needs no reset: contents are only visible through a non-empty FIFO.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= {plot_addr, vga_color};
  end

endmodule
